// File: rtl/multi_edge_detector.sv
// multi_edge_detector
//   Multi-channel edge detector. Each channel reports rising, falling or any
//   edge (selected by mode for all channels) as a registered one-cycle pulse.
//   It also keeps a sticky flag per channel and a saturating total of all
//   detected edges.
//
//   Optional macro: EDGE_DET_SYNC_EN. When it is defined, a SYNC_STAGES-deep
//   synchroniser sits ahead of detection. Latency and arming both grow by
//   SYNC_STAGES. When it is undefined, din must already be synchronous to clk.
//
// Parameters: WIDTH (1..32) channels, CNT_WIDTH counter width,
//             SYNC_STAGES (2..4) synchroniser depth
// Ports:
//   clk, reset      clock and synchronous active-high reset
//   din[WIDTH]      monitored signals
//   mode[2]         00 rise, 01 fall, 10 both, 11 off
//   clear_sticky    per-channel sticky clear (level); a same-cycle edge wins
//   count_clear     clears edge_count; edges in the same cycle still count
//   delay_din       previous sample of each channel
//   edge_detected   one-cycle edge pulses
//   sticky          latched edge flags
//   edge_count      saturating edge total

module multi_edge_detector_lane (
  input  logic       clk,
  input  logic       reset,
  input  logic       s,
  input  logic       armed,
  input  logic [1:0] mode,
  input  logic       clear,
  output logic       dly_q,
  output logic       edge_q,
  output logic       sticky_q,
  output logic       new_edge
);
  logic hit;

  always_comb begin
    hit = 1'b0;
    case (mode)
      2'b00:   hit = s & ~dly_q;
      2'b01:   hit = ~s & dly_q;
      2'b10:   hit = s ^ dly_q;
      default: hit = 1'b0;
    endcase
    new_edge = armed & hit;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dly_q    <= 1'b0;
      edge_q   <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      dly_q    <= s;
      edge_q   <= new_edge;
      sticky_q <= (sticky_q & ~clear) | new_edge;
    end
  end
endmodule

module multi_edge_detector #(
  parameter int WIDTH       = 8,
  parameter int CNT_WIDTH   = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     din,
  input  logic [1:0]           mode,
  input  logic [WIDTH-1:0]     clear_sticky,
  input  logic                 count_clear,
  output logic [WIDTH-1:0]     delay_din,
  output logic [WIDTH-1:0]     edge_detected,
  output logic [WIDTH-1:0]     sticky,
  output logic [CNT_WIDTH-1:0] edge_count
);
  // Cycles after reset until delay_din holds real history.
`ifdef EDGE_DET_SYNC_EN
  localparam int STAGES = SYNC_STAGES + 1;
`else
  localparam int STAGES = 1;
`endif
  localparam int PW    = $clog2(WIDTH + 1);
  localparam int SUM_W = CNT_WIDTH + PW;

  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $error("multi_edge_detector: WIDTH out of range");
  end
  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
    $error("multi_edge_detector: SYNC_STAGES out of range");
  end

  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] new_edge;

`ifdef EDGE_DET_SYNC_EN
  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  always_ff @(posedge clk) begin
    if (reset) sync_q <= '0;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], din};
  end
  assign s = sync_q[SYNC_STAGES-1];
`else
  assign s = din;
`endif

  // A one shifts in after reset. Detection arms when it reaches the top bit,
  // so levels already present at reset release never count as edges.
  logic [STAGES-1:0] vld_pipe;
  logic              armed;
  always_ff @(posedge clk) begin
    if (reset) vld_pipe <= '0;
    else       vld_pipe <= (vld_pipe << 1) | STAGES'(1);
  end
  assign armed = vld_pipe[STAGES-1];

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    multi_edge_detector_lane u_lane (
      .clk      (clk),
      .reset    (reset),
      .s        (s[i]),
      .armed    (armed),
      .mode     (mode),
      .clear    (clear_sticky[i]),
      .dly_q    (delay_din[i]),
      .edge_q   (edge_detected[i]),
      .sticky_q (sticky[i]),
      .new_edge (new_edge[i])
    );
  end

  // Saturating count. The adder is wide enough that the sum cannot wrap
  // before it is clamped.
  logic [PW-1:0]        pop;
  logic [SUM_W-1:0]     sum;
  logic [CNT_WIDTH-1:0] cnt_nxt;
  always_comb begin
    pop = '0;
    for (int i = 0; i < WIDTH; i++) pop = pop + PW'(new_edge[i]);
    sum     = (count_clear ? '0 : SUM_W'(edge_count)) + SUM_W'(pop);
    cnt_nxt = (sum[SUM_W-1:CNT_WIDTH] != '0) ? '1 : sum[CNT_WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) edge_count <= '0;
    else       edge_count <= cnt_nxt;
  end
endmodule

// File: tb/tb_multi_edge_detector.sv
module tb_multi_edge_detector;
`ifdef EDGE_DET_SYNC_EN
  localparam int SS  = 3;
  localparam int LAT = SS;
`else
  localparam int SS  = 2;
  localparam int LAT = 0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] din, clear_sticky;
  logic [1:0] mode;
  logic       count_clear;
  logic [7:0] delay_din, edge_detected, sticky;
  logic [7:0] edge_count;

  logic [7:0] din_s, clr_s, dly_s, edge_s, stk_s;
  logic [1:0] mode_s;
  logic       cc_s;
  logic [3:0] cnt_s;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  multi_edge_detector #(.WIDTH(8), .CNT_WIDTH(8), .SYNC_STAGES(SS)) u_dut (
    .clk(clk), .reset(reset), .din(din), .mode(mode),
    .clear_sticky(clear_sticky), .count_clear(count_clear),
    .delay_din(delay_din), .edge_detected(edge_detected),
    .sticky(sticky), .edge_count(edge_count));

  multi_edge_detector #(.WIDTH(8), .CNT_WIDTH(4), .SYNC_STAGES(SS)) u_sat (
    .clk(clk), .reset(reset), .din(din_s), .mode(mode_s),
    .clear_sticky(clr_s), .count_clear(cc_s),
    .delay_din(dly_s), .edge_detected(edge_s),
    .sticky(stk_s), .edge_count(cnt_s));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hold the current inputs long enough for the change to reach the outputs.
  task automatic step();
    tick();
    repeat (LAT) tick();
  endtask

  initial begin
    reset = 1'b1; din = 8'hFF; mode = 2'b00; clear_sticky = '0; count_clear = 1'b0;
    din_s = '0; mode_s = 2'b10; clr_s = '0; cc_s = 1'b0;
    tick(); tick();
    chk("rst_delay", delay_din, 8'h00);
    chk("rst_edge", edge_detected, 8'h00);
    chk("rst_sticky", sticky, 8'h00);
    chk("rst_count", edge_count, 8'h00);

    // Lines already high at release must not give a rising edge.
    reset = 1'b0;
    step();
    chk("arm_edge", edge_detected, 8'h00);
    chk("arm_delay", delay_din, 8'hFF);
    step();
    chk("hold_edge", edge_detected, 8'h00);
    chk("hold_sticky", sticky, 8'h00);
    chk("hold_count", edge_count, 8'h00);

    // Rising mode.
    din = 8'h00; step();
    chk("r_fall_ignored", edge_detected, 8'h00);
    din = 8'h01; step();
    chk("r_pulse", edge_detected, 8'h01);
    chk("r_sticky", sticky, 8'h01);
    chk("r_count", edge_count, 8'd1);
    step();
    chk("r_pulse_end", edge_detected, 8'h00);
    step();
    din = 8'h00; step();
    chk("r_fall_edge", edge_detected, 8'h00);
    chk("r_count2", edge_count, 8'd1);

    // Falling mode.
    mode = 2'b01;
    din = 8'h01; step();
    chk("f_rise_ignored", edge_detected, 8'h00);
    din = 8'h00; step();
    chk("f_pulse", edge_detected, 8'h01);
    chk("f_count", edge_count, 8'd2);

    // Both edges.
    mode = 2'b10;
    din = 8'h0F; step();
    chk("b_0f", edge_detected, 8'h0F);
    chk("b_count6", edge_count, 8'd6);
    din = 8'hF0; step();
    chk("b_all", edge_detected, 8'hFF);
    chk("b_count14", edge_count, 8'd14);
    chk("b_sticky", sticky, 8'hFF);

    // A sticky clear in the same cycle as an edge leaves that bit set.
    clear_sticky = 8'hFF; din = 8'hF4; step();
    chk("clr_edge", edge_detected, 8'h04);
    chk("clr_set_wins", sticky, 8'h04);
    chk("clr_count", edge_count, 8'd15);
    step();
    chk("clr_done", sticky, 8'h00);
    clear_sticky = '0;

    // Disabled mode. Switching back must not replay the missed change.
    mode = 2'b11; din = 8'h0B; step();
    chk("off_edge", edge_detected, 8'h00);
    chk("off_count", edge_count, 8'd15);
    mode = 2'b10; step();
    chk("mode_back_edge", edge_detected, 8'h00);
    chk("mode_back_delay", delay_din, 8'h0B);

    // Toggling every cycle gives a pulse every cycle.
    din = 8'h8B; step();
    chk("tog1", edge_detected, 8'h80);
    din = 8'h0B; step();
    chk("tog2", edge_detected, 8'h80);
    din = 8'h8B; step();
    chk("tog3", edge_detected, 8'h80);
    chk("tog_count", edge_count, 8'd18);

    // Edges that arrive with count_clear are still counted.
    count_clear = 1'b1; din = 8'h8C; step();
    chk("cc_edge", edge_detected, 8'h07);
    chk("cc_count", edge_count, 8'd3);
    count_clear = 1'b0;

    // Reset while a change is still in flight.
    din = 8'h00; tick();
    reset = 1'b1; step();
    chk("mid_rst_edge", edge_detected, 8'h00);
    chk("mid_rst_sticky", sticky, 8'h00);
    chk("mid_rst_count", edge_count, 8'h00);
    chk("mid_rst_delay", delay_din, 8'h00);
    reset = 1'b0; din = 8'hFF; step();
    chk("rearm_edge", edge_detected, 8'h00);
    step();
    chk("rearm_edge2", edge_detected, 8'h00);
    chk("rearm_count", edge_count, 8'h00);

    // The 4-bit counter saturates at 15.
    for (int i = 0; i < 20; i++) begin
      din_s = din_s ^ 8'h01; step();
    end
    chk("sat_edge", edge_s, 8'h01);
    chk("sat_count", cnt_s, 4'd15);
    cc_s = 1'b1; din_s = din_s ^ 8'h0E; step();
    chk("sat_cc_edge", edge_s, 8'h0E);
    chk("sat_cc_count", cnt_s, 4'd3);
    cc_s = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/multi_edge_detector.md
# multi_edge_detector

Parametrised multi-channel edge detector: per-channel rising/falling/any-edge detection with selectable mode, registered single-cycle pulses, sticky event flags with per-bit clear, and a saturating event counter. It is the general-purpose edge-detection block for monitoring slow control/status lines; optional input synchronisers allow asynchronous sources.

## Interface
- WIDTH, 8, number of independent channels (1..32)
- CNT_WIDTH, 8, width of the event counter
- SYNC_STAGES, 2, synchroniser depth (2..4); used only when EDGE_DET_SYNC_EN is defined
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high; one clock, one synchronous active-high reset
- din  input  WIDTH  monitored signals
- mode  input  2  00 rising, 01 falling, 10 both, 11 detection disabled (applies to all channels)
- clear_sticky  input  WIDTH  per-channel sticky clear, level-sensitive
- count_clear  input  1  clears edge_count
- delay_din  output  WIDTH  sampled value of the previous cycle (s delayed by one clock)
- edge_detected  output  WIDTH  registered one-cycle pulse per detected edge
- sticky  output  WIDTH  per-channel latched edge flag
- edge_count  output  CNT_WIDTH  saturating total of detected edges, all channels

## Operation
- s = sampled input: din directly (macro off) or last stage of synchroniser (macro on).
- Each clk: delay_din <= s; edge_detected[i] <= armed & f(mode, s[i], delay_din[i]); rise = s & ~delay_din, fall = ~s & delay_din, both = s ^ delay_din, mode 11 -> 0.
- Arming: after reset, detection is suppressed until the pipeline holds valid history — 1 sampling cycle (macro off) or SYNC_STAGES+1 cycles (macro on). Signals already high at reset release never produce a rising edge.
- sticky[i] <= (sticky[i] & ~clear_sticky[i]) | new_edge[i]; set and clear in the same cycle -> set wins (sticky stays 1).
- edge_count <= min(edge_count + popcount(new_edge), 2^CNT_WIDTH-1); saturates, never wraps.
- count_clear with edges in same cycle: edge_count <= popcount(new_edge) (no lost events).
- mode change takes effect on the next clk edge; history (delay_din) is unaffected, so a level change before the mode switch is not reported retroactively.
- new_edge = value being registered into edge_detected in that cycle.

## Timing
- Reset (sync, active-high) values: delay_din=0, edge_detected=0, sticky=0, edge_count=0, synchroniser flops=0, armed=0.
- Macro off: din sampled at edge k differing from sample at k-1 -> edge_detected high from edge k to k+1 (1-cycle latency after sampling). sticky and edge_count update at the same edge k.
- Macro on: add SYNC_STAGES cycles latency.
- A din pulse must be stable across at least one sampling edge to be seen; a level held N cycles produces exactly one pulse.
- Toggling every cycle in mode 10 produces edge_detected held high continuously (one pulse per cycle).
- Reset asserted mid-operation: all state cleared at that edge; pending pulses dropped; re-arm sequence restarts.

## Configuration
- EDGE_DET_SYNC_EN: defined -> SYNC_STAGES-deep flop chain per channel ahead of detection, latency +SYNC_STAGES, arming extended accordingly. Undefined -> din used directly (must be synchronous to clk), no synchroniser flops instantiated.

## Test plan
- Reset with din=8'hFF, release, hold -> no edge_detected, sticky=0, edge_count=0; delay_din=8'hFF after arming.
- mode=00, din[0] 0->1 sampled at edge k, back to 0 at k+3 -> edge_detected=8'h01 for exactly cycle k..k+1; sticky[0]=1; edge_count=1; mode=01 repeat -> pulse on 1->0 only.
- mode=10, din=8'h0F -> 8'hF0 in one cycle -> edge_detected=8'hFF one cycle, edge_count += 8.
- CNT_WIDTH=4, 20 edges -> edge_count stops at 15; count_clear with 3 simultaneous edges -> edge_count=3.
- clear_sticky[2] asserted same cycle as edge on ch2 -> sticky[2] stays 1; next cycle with clear and no edge -> 0.
- Macro on, SYNC_STAGES=3: rising din[5] -> edge_detected[5] exactly 3 cycles later than macro-off build; reset mid-pipeline -> no pulse emitted.
